// File: rtl/aux_snapshot_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : aux_snapshot_scheduler_if
//  Purpose  : Signal bundle between the aux snapshot scheduler and its
//             surroundings: frame trigger, CPU register vector, CPU memory
//             read port, aux memory write port and status flags.
//             The master modport is the scheduler side; slave is the
//             environment (CPU, memory arbiter, aux memory).
//  Revision : 1.0 - initial release
// ============================================================================
interface aux_snapshot_scheduler_if #(
   parameter int DATA_WIDTH           = 16,
   parameter int MEMORY_ADDRESS_WIDTH = 11,
   parameter int AUX_ADDRESS_WIDTH    = 5,
   parameter int CPU_ELEMENTS         = 10
);
   // Frame trigger and register snapshot source
   logic                               frame_start_in;
   logic [CPU_ELEMENTS*DATA_WIDTH-1:0] cpu_regs_in;

   // Shared CPU memory read port
   logic                               mem_req_out;
   logic                               mem_sel_out;
   logic [MEMORY_ADDRESS_WIDTH-1:0]    mem_addr_out;
   logic                               mem_gnt_in;
   logic                               mem_rvalid_in;
   logic [DATA_WIDTH-1:0]              mem_rdata_in;

   // Aux memory write port
   logic                               aux_we_out;
   logic [AUX_ADDRESS_WIDTH-1:0]       aux_waddress_out;
   logic [DATA_WIDTH-1:0]              aux_wdata_out;

   // Status
   logic                               busy_out;
   logic                               done_out;
   logic                               skipped_out;

   modport master (
      input  frame_start_in, cpu_regs_in,
      output mem_req_out, mem_sel_out, mem_addr_out,
      input  mem_gnt_in, mem_rvalid_in, mem_rdata_in,
      output aux_we_out, aux_waddress_out, aux_wdata_out,
      output busy_out, done_out, skipped_out
   );

   modport slave (
      output frame_start_in, cpu_regs_in,
      input  mem_req_out, mem_sel_out, mem_addr_out,
      output mem_gnt_in, mem_rvalid_in, mem_rdata_in,
      input  aux_we_out, aux_waddress_out, aux_wdata_out,
      input  busy_out, done_out, skipped_out
   );
endinterface
`default_nettype wire

// File: rtl/aux_snapshot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : aux_snapshot_scheduler
//  Purpose  : Once per frame, fills the debug aux memory read by the VGA
//             frame generator: a coherent copy of the CPU registers (slots
//             0..CPU_ELEMENTS-1), followed by an instruction-memory window
//             centred on the PC and a data-memory window centred on the data
//             address register, fetched one word at a time through the shared
//             CPU memory read port.
//  Options  : AUX_SNAPSHOT_TIMEOUT_EN - when defined, a stalled grant or read
//             response is abandoned after TIMEOUT_CYCLES and the slot is
//             filled with 'hDEAD.
//  Revision : 1.0 - initial release
// ============================================================================
module aux_snapshot_scheduler #(
   parameter int DATA_WIDTH           = 16,
   parameter int MEMORY_ADDRESS_WIDTH = 11,
   parameter int AUX_ADDRESS_WIDTH    = 5,
   parameter int CPU_ELEMENTS         = 10,
   parameter int MEMORY_ELEMENTS      = 10,
   parameter int TIMEOUT_CYCLES       = 255
) (
   input  wire logic                  clk_in,
   input  wire logic                  reset_in,
   aux_snapshot_scheduler_if.master   bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_WIN_WORDS = 2 * MEMORY_ELEMENTS;
   localparam int c_K_W       = $clog2(c_WIN_WORDS);
   localparam int c_R_W       = (CPU_ELEMENTS > 1) ? $clog2(CPU_ELEMENTS) : 1;

   localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_WIN_WORDS - 1);
   localparam logic [c_K_W-1:0] c_K_DATA = c_K_W'(MEMORY_ELEMENTS);
   localparam logic [c_R_W-1:0] c_R_LAST = c_R_W'(CPU_ELEMENTS - 1);

   // Window placement: four words before the pointer, clamped so the whole
   // window stays inside the memory. Comparisons are done at full register
   // width so pointer values above the memory size clamp to the top window.
   localparam logic [DATA_WIDTH-1:0] c_LAST     = DATA_WIDTH'((1 << MEMORY_ADDRESS_WIDTH) - 1);
   localparam logic [DATA_WIDTH-1:0] c_LEAD     = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] c_LOW_LIM  = DATA_WIDTH'(5);
   localparam logic [DATA_WIDTH-1:0] c_HIGH_LIM = c_LAST - c_LOW_LIM;
   localparam logic [DATA_WIDTH-1:0] c_TOP_BASE = c_LAST - DATA_WIDTH'(MEMORY_ELEMENTS - 1);

   localparam logic [AUX_ADDRESS_WIDTH-1:0] c_AUX_WIN_BASE = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS);
   localparam logic [DATA_WIDTH-1:0]        c_DEAD         = DATA_WIDTH'(16'hDEAD);

   // Register indices holding the program counter and the data address
   localparam int c_PC_IDX   = 0;
   localparam int c_DADR_IDX = 2;

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CAPTURE  = 3'd1,
      S_REG_WR   = 3'd2,
      S_WIN_REQ  = 3'd3,
      S_WIN_WAIT = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t                          r_state;
   state_t                          w_next;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]           r_snap [CPU_ELEMENTS];
   logic [MEMORY_ADDRESS_WIDTH-1:0] r_ibase;
   logic [MEMORY_ADDRESS_WIDTH-1:0] r_dbase;
   logic [c_R_W-1:0]                r_reg_idx;
   logic [c_K_W-1:0]                r_k;
   logic                            r_wr_pend;
   logic [AUX_ADDRESS_WIDTH-1:0]    r_wr_addr;
   logic [DATA_WIDTH-1:0]           r_wr_data;
   logic                            r_skipped;

   // Window word k completes this cycle, with the value to store for it
   logic                            w_adv;
   logic [DATA_WIDTH-1:0]           w_adv_data;

   // Current window request
   logic                            w_win_sel;
   logic [c_K_W-1:0]                w_win_off;
   logic [MEMORY_ADDRESS_WIDTH-1:0] w_win_addr;

   // Base address of a window for a given pointer register value
   function automatic logic [MEMORY_ADDRESS_WIDTH-1:0] f_base(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] b;
      if (v < c_LOW_LIM) begin
         b = '0;
      end else if (v > c_HIGH_LIM) begin
         b = c_TOP_BASE;
      end else begin
         b = v - c_LEAD;
      end
      return MEMORY_ADDRESS_WIDTH'(b);
   endfunction

   // Words 0..MEMORY_ELEMENTS-1 come from instruction memory, the rest from
   // data memory; bases are clamped so base+offset never wraps.
   assign w_win_sel  = (r_k >= c_K_DATA);
   assign w_win_off  = w_win_sel ? (r_k - c_K_DATA) : r_k;
   assign w_win_addr = (w_win_sel ? r_dbase : r_ibase) + MEMORY_ADDRESS_WIDTH'(w_win_off);

`ifdef AUX_SNAPSHOT_TIMEOUT_EN
   localparam int c_TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TMO_W-1:0] r_tmo_cnt;
   logic               w_tmo_hit;

   // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent waiting
   assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

   // Cycles spent in the current wait state; cleared on every state change
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_tmo_cnt <= '0;
      end else if (((r_state == S_WIN_REQ) || (r_state == S_WIN_WAIT)) && (w_next == r_state)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end
`endif

   // State register
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and all outputs
   always_comb begin
      w_next               = r_state;
      w_adv                = 1'b0;
      w_adv_data           = bus.mem_rdata_in;
      bus.mem_req_out      = 1'b0;
      bus.mem_sel_out      = 1'b0;
      bus.mem_addr_out     = '0;
      bus.aux_we_out       = 1'b0;
      bus.aux_waddress_out = '0;
      bus.aux_wdata_out    = '0;
      bus.busy_out         = (r_state != S_IDLE);
      bus.done_out         = (r_state == S_DONE);
      bus.skipped_out      = r_skipped;

      // A fetched word lands one cycle after its response, possibly while
      // the next request is already being presented.
      if (r_wr_pend) begin
         bus.aux_we_out       = 1'b1;
         bus.aux_waddress_out = r_wr_addr;
         bus.aux_wdata_out    = r_wr_data;
      end

      case (r_state)
         S_IDLE: begin
            if (bus.frame_start_in) begin
               w_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_next = S_REG_WR;
         end
         S_REG_WR: begin
            bus.aux_we_out       = 1'b1;
            bus.aux_waddress_out = AUX_ADDRESS_WIDTH'(r_reg_idx);
            bus.aux_wdata_out    = r_snap[r_reg_idx];
            if (r_reg_idx == c_R_LAST) begin
               w_next = S_WIN_REQ;
            end
         end
         S_WIN_REQ: begin
            bus.mem_req_out  = 1'b1;
            bus.mem_sel_out  = w_win_sel;
            bus.mem_addr_out = w_win_addr;
            if (bus.mem_gnt_in) begin
               w_next = S_WIN_WAIT;
            end
`ifdef AUX_SNAPSHOT_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_adv      = 1'b1;
               w_adv_data = c_DEAD;
            end
`endif
         end
         S_WIN_WAIT: begin
            if (bus.mem_rvalid_in) begin
               w_adv = 1'b1;
            end
`ifdef AUX_SNAPSHOT_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_adv      = 1'b1;
               w_adv_data = c_DEAD;
            end
`endif
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      if (w_adv) begin
         w_next = (r_k == c_K_LAST) ? S_DONE : S_WIN_REQ;
      end
   end

   // Snapshot capture, window bases, word counters and the delayed aux write
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < CPU_ELEMENTS; i++) begin
            r_snap[i] <= '0;
         end
         r_ibase   <= '0;
         r_dbase   <= '0;
         r_reg_idx <= '0;
         r_k       <= '0;
         r_wr_pend <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_pend <= w_adv;
         if (w_adv) begin
            r_wr_addr <= c_AUX_WIN_BASE + AUX_ADDRESS_WIDTH'(r_k);
            r_wr_data <= w_adv_data;
            r_k       <= r_k + 1'b1;
         end
         case (r_state)
            S_CAPTURE: begin
               for (int i = 0; i < CPU_ELEMENTS; i++) begin
                  r_snap[i] <= bus.cpu_regs_in[i*DATA_WIDTH +: DATA_WIDTH];
               end
               r_ibase   <= f_base(bus.cpu_regs_in[c_PC_IDX*DATA_WIDTH +: DATA_WIDTH]);
               r_dbase   <= f_base(bus.cpu_regs_in[c_DADR_IDX*DATA_WIDTH +: DATA_WIDTH]);
               r_reg_idx <= '0;
               r_k       <= '0;
            end
            S_REG_WR: begin
               r_reg_idx <= r_reg_idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Sticky flag: a frame trigger arrived while a snapshot was in progress
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_skipped <= 1'b0;
      end else if (bus.frame_start_in && (r_state != S_IDLE)) begin
         r_skipped <= 1'b1;
      end
   end

endmodule
`default_nettype wire
